// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: debounces start/stop and lap/clear buttons,
// runs the IDLE/RUN/PAUSE/LAP machine and generates the count tick.
module stopwatch_ctrl #(
  parameter int TICK_DIV   = 500000,
  parameter int DEB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_ss,
  input  logic       btn_lc,
  output logic       cnt_en,
  output logic       cnt_rst,
  output logic       disp_freeze,
  output logic [1:0] state_o
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_LAP   = 2'b11
  } state_t;

  logic [1:0]    w_btn_raw;
  logic [1:0]    w_press;
  state_t        r_state;
  state_t        w_state_next;
  logic [PW-1:0] r_presc;
  logic [PW-1:0] w_presc_next;
  logic          w_counting;
  logic          w_tick_last;
  logic          w_ss;
  logic          w_lc;

  assign w_btn_raw = {btn_lc, btn_ss};

  // Bit 0 is start/stop, bit 1 is lap/clear; both buttons share one path.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic          r_s1;
      logic          r_s2;
      logic          r_deb;
      logic          r_deb_d;
      logic [DW-1:0] r_cnt;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_s1    <= 1'b0;
          r_s2    <= 1'b0;
          r_deb   <= 1'b0;
          r_deb_d <= 1'b0;
          r_cnt   <= '0;
        end else begin
          r_s1    <= w_btn_raw[gi];
          r_s2    <= r_s1;
          r_deb_d <= r_deb;
          if (r_s2 == r_deb) begin
            r_cnt <= '0;
          end else if (r_cnt == DW'(DEB_CYCLES - 1)) begin
            r_deb <= r_s2;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + DW'(1);
          end
        end
      end

      assign w_press[gi] = r_deb & ~r_deb_d;
    end
  endgenerate

  assign w_ss = w_press[0];
  assign w_lc = w_press[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_presc <= '0;
    end else begin
      r_state <= w_state_next;
      r_presc <= w_presc_next;
    end
  end

  // Start/stop is checked first so it wins over a same-cycle lap/clear.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_ss) w_state_next = S_RUN;
      S_RUN:   if (w_ss) w_state_next = S_PAUSE;
               else if (w_lc) w_state_next = S_LAP;
      S_LAP:   if (w_ss) w_state_next = S_PAUSE;
               else if (w_lc) w_state_next = S_RUN;
      S_PAUSE: if (w_ss) w_state_next = S_RUN;
               else if (w_lc) w_state_next = S_IDLE;
      default: w_state_next = r_state;
    endcase
  end

  assign w_counting  = (r_state == S_RUN) || (r_state == S_LAP);
  assign w_tick_last = (r_presc == PW'(TICK_DIV - 1));

  // Counting follows the pre-edge state; PAUSE holds phase, IDLE zeroes it.
  always_comb begin
    w_presc_next = r_presc;
    if (r_state == S_IDLE || w_state_next == S_IDLE) begin
      w_presc_next = '0;
    end else if (w_counting) begin
      w_presc_next = w_tick_last ? '0 : r_presc + PW'(1);
    end
  end

  assign cnt_en      = w_counting && w_tick_last;
  assign cnt_rst     = (r_state == S_IDLE);
  assign disp_freeze = (r_state == S_LAP);
  assign state_o     = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus random
// button traffic, all compared against a behavioural model.
module tb_stopwatch_ctrl;

  localparam int TICK_DIV   = 4;
  localparam int DEB_CYCLES = 2;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam logic [1:0] ST_LAP   = 2'b11;

  logic       clk;
  logic       reset;
  logic       btn_ss;
  logic       btn_lc;
  logic       cnt_en;
  logic       cnt_rst;
  logic       disp_freeze;
  logic [1:0] state_o;

  int errors;
  int checks;

  // Model: state, tick phase, and per-button sampled history / debounced level.
  logic [1:0]  m_st;
  int          m_presc;
  logic        m_s1    [2];
  logic        m_s2    [2];
  logic        m_deb   [2];
  logic        m_press [2];
  logic [31:0] m_hist  [2];

  stopwatch_ctrl #(
    .TICK_DIV  (TICK_DIV),
    .DEB_CYCLES(DEB_CYCLES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_ss     (btn_ss),
    .btn_lc     (btn_lc),
    .cnt_en     (cnt_en),
    .cnt_rst    (cnt_rst),
    .disp_freeze(disp_freeze),
    .state_o    (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    m_st    = ST_IDLE;
    m_presc = 0;
    for (int b = 0; b < 2; b++) begin
      m_s1[b] = 1'b0; m_s2[b] = 1'b0; m_deb[b] = 1'b0;
      m_press[b] = 1'b0; m_hist[b] = '0;
    end
  endtask

  // A button level is accepted once the last DEB_CYCLES synchronised samples
  // all disagree with the current debounced level; a rise is one press.
  task automatic model_edge();
    logic [1:0]  nst;
    logic [1:0]  raw;
    logic [31:0] mask;
    logic        ss, lc;
    ss   = m_press[0];
    lc   = m_press[1];
    raw  = {btn_lc, btn_ss};
    mask = (32'd1 << DEB_CYCLES) - 32'd1;
    nst  = m_st;
    case (m_st)
      ST_IDLE:  if (ss) nst = ST_RUN;
      ST_RUN:   if (ss) nst = ST_PAUSE; else if (lc) nst = ST_LAP;
      ST_LAP:   if (ss) nst = ST_PAUSE; else if (lc) nst = ST_RUN;
      default:  if (ss) nst = ST_RUN;   else if (lc) nst = ST_IDLE;
    endcase
    if (m_st == ST_IDLE || nst == ST_IDLE) m_presc = 0;
    else if (m_st == ST_RUN || m_st == ST_LAP) m_presc = (m_presc + 1) % TICK_DIV;
    for (int b = 0; b < 2; b++) begin
      m_hist[b] = {m_hist[b][30:0], m_s2[b]};
      if ((m_hist[b] & mask) == (m_deb[b] ? 32'd0 : mask)) begin
        m_deb[b]   = ~m_deb[b];
        m_press[b] = m_deb[b];
      end else begin
        m_press[b] = 1'b0;
      end
      m_s2[b] = m_s1[b];
      m_s1[b] = raw[b];
    end
    m_st = nst;
  endtask

  function automatic logic [4:0] m_outs();
    logic en;
    en = (m_st == ST_RUN || m_st == ST_LAP) && (m_presc == TICK_DIV - 1);
    return {en, m_st == ST_IDLE, m_st == ST_LAP, m_st};
  endfunction

  // Advance one clock; afterwards we sit 1 time unit past the edge.
  task automatic step();
    @(posedge clk);
    if (reset) model_clear();
    else model_edge();
    #1;
  endtask

  task automatic press_btn(input logic ss, input logic lc, input int hold);
    btn_ss = ss;
    btn_lc = lc;
    repeat (hold) step();
    btn_ss = 1'b0;
    btn_lc = 1'b0;
    repeat (DEB_CYCLES + 4) step();
  endtask

  task automatic test_reset();
    reset = 1'b1; btn_ss = 1'b0; btn_lc = 1'b0;
    model_clear();
    #3;
    checks++;
    if ({cnt_en, cnt_rst, disp_freeze, state_o} !== 5'b01000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b",
               {cnt_en, cnt_rst, disp_freeze, state_o}, 5'b01000);
    end
    step(); step();
    reset = 1'b0;
    step();
    checks++;
    if ({cnt_en, cnt_rst, disp_freeze, state_o} !== m_outs()) begin
      errors++;
      $display("FAIL reset_release: got %b expected %b",
               {cnt_en, cnt_rst, disp_freeze, state_o}, m_outs());
    end
  endtask

  task automatic test_start_hold();
    logic [1:0] exp_st;
    int pulses;
    btn_ss = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      exp_st = (k >= 5) ? ST_RUN : ST_IDLE;
      checks++;
      if (state_o !== exp_st) begin
        errors++;
        $display("FAIL start_edge k=%0d: got %b expected %b", k, state_o, exp_st);
      end
      checks++;
      if ({cnt_en, cnt_rst, disp_freeze, state_o} !== m_outs()) begin
        errors++;
        $display("FAIL start_model k=%0d: got %b expected %b", k,
                 {cnt_en, cnt_rst, disp_freeze, state_o}, m_outs());
      end
    end
    btn_ss = 1'b0;
    pulses = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (cnt_en === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 4 || state_o !== ST_RUN) begin
      errors++;
      $display("FAIL run_pulses: got %0d pulses state %b expected 4 pulses state 01",
               pulses, state_o);
    end
  endtask

  task automatic test_glitch_lap();
    int pulses;
    btn_lc = 1'b1;
    step();
    btn_lc = 1'b0;
    repeat (8) step();
    checks++;
    if (state_o !== ST_RUN) begin
      errors++;
      $display("FAIL glitch_reject: got %b expected %b", state_o, ST_RUN);
    end
    press_btn(1'b0, 1'b1, 4);
    checks++;
    if (state_o !== ST_LAP || disp_freeze !== 1'b1) begin
      errors++;
      $display("FAIL lap_enter: got state %b freeze %b expected state 11 freeze 1",
               state_o, disp_freeze);
    end
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (cnt_en === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 3) begin
      errors++;
      $display("FAIL lap_pulses: got %0d expected 3", pulses);
    end
    press_btn(1'b0, 1'b1, 4);
    checks++;
    if (state_o !== ST_RUN || disp_freeze !== 1'b0) begin
      errors++;
      $display("FAIL lap_exit: got state %b freeze %b expected state 01 freeze 0",
               state_o, disp_freeze);
    end
  endtask

  task automatic test_pause_resume();
    int pulses;
    for (int i = 0; i < 8 && m_presc != 1; i++) step();
    btn_ss = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      if (k == 5) btn_ss = 1'b0;
      step();
    end
    checks++;
    if (state_o !== ST_PAUSE || cnt_en !== 1'b0) begin
      errors++;
      $display("FAIL pause_enter: got state %b en %b expected state 10 en 0",
               state_o, cnt_en);
    end
    pulses = 0;
    for (int k = 0; k < 9; k++) begin
      step();
      if (cnt_en !== 1'b0) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL pause_quiet: got %0d pulses expected 0", pulses);
    end
    btn_ss = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      if (k == 5) btn_ss = 1'b0;
      step();
    end
    checks++;
    if (state_o !== ST_RUN || cnt_en !== 1'b0) begin
      errors++;
      $display("FAIL resume_state: got state %b en %b expected state 01 en 0",
               state_o, cnt_en);
    end
    step();
    checks++;
    if (cnt_en !== 1'b1) begin
      errors++;
      $display("FAIL resume_phase: got en %b expected 1", cnt_en);
    end
    repeat (6) step();
  endtask

  task automatic test_clear();
    press_btn(1'b1, 1'b0, 4);
    checks++;
    if (state_o !== ST_PAUSE) begin
      errors++;
      $display("FAIL clear_pause: got %b expected %b", state_o, ST_PAUSE);
    end
    press_btn(1'b0, 1'b1, 4);
    checks++;
    if (state_o !== ST_IDLE || cnt_rst !== 1'b1 || cnt_en !== 1'b0) begin
      errors++;
      $display("FAIL clear_idle: got state %b rst %b en %b expected 00 1 0",
               state_o, cnt_rst, cnt_en);
    end
    press_btn(1'b0, 1'b1, 4);
    checks++;
    if (state_o !== ST_IDLE) begin
      errors++;
      $display("FAIL idle_lc_ignored: got %b expected %b", state_o, ST_IDLE);
    end
    btn_ss = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      if (k == 5) btn_ss = 1'b0;
      step();
    end
    checks++;
    if (state_o !== ST_RUN || cnt_en !== 1'b0) begin
      errors++;
      $display("FAIL restart_state: got state %b en %b expected 01 0", state_o, cnt_en);
    end
    for (int j = 1; j <= 4; j++) begin
      step();
      checks++;
      if (cnt_en !== (j == 3)) begin
        errors++;
        $display("FAIL restart_phase j=%0d: got en %b expected %b", j, cnt_en, (j == 3));
      end
    end
    repeat (4) step();
  endtask

  task automatic test_simultaneous();
    press_btn(1'b1, 1'b1, 4);
    checks++;
    if (state_o !== ST_PAUSE || disp_freeze !== 1'b0) begin
      errors++;
      $display("FAIL simultaneous: got state %b freeze %b expected 10 0",
               state_o, disp_freeze);
    end
  endtask

  task automatic test_reset_midrun();
    press_btn(1'b1, 1'b0, 4);
    press_btn(1'b0, 1'b1, 4);
    checks++;
    if (state_o !== ST_LAP) begin
      errors++;
      $display("FAIL midreset_setup: got %b expected %b", state_o, ST_LAP);
    end
    for (int i = 0; i < 8 && m_presc != 2; i++) step();
    #2;
    reset = 1'b1;
    #1;
    model_clear();
    checks++;
    if ({cnt_en, cnt_rst, disp_freeze, state_o} !== 5'b01000) begin
      errors++;
      $display("FAIL midreset_async: got %b expected %b",
               {cnt_en, cnt_rst, disp_freeze, state_o}, 5'b01000);
    end
    step(); step();
    reset = 1'b0;
    repeat (3) step();
    checks++;
    if ({cnt_en, cnt_rst, disp_freeze, state_o} !== m_outs()) begin
      errors++;
      $display("FAIL midreset_after: got %b expected %b",
               {cnt_en, cnt_rst, disp_freeze, state_o}, m_outs());
    end
  endtask

  task automatic test_random();
    int left_ss, left_lc;
    left_ss = 0;
    left_lc = 0;
    for (int n = 0; n < 900; n++) begin
      if ($urandom_range(0, 249) == 0) begin
        reset = 1'b1;
        #1;
        model_clear();
        checks++;
        if ({cnt_en, cnt_rst, disp_freeze, state_o} !== 5'b01000) begin
          errors++;
          $display("FAIL random_reset n=%0d: got %b expected %b", n,
                   {cnt_en, cnt_rst, disp_freeze, state_o}, 5'b01000);
        end
        step();
        reset = 1'b0;
      end
      if (left_ss == 0) begin
        btn_ss  = ($urandom_range(0, 2) == 0);
        left_ss = $urandom_range(1, 9);
      end
      if (left_lc == 0) begin
        btn_lc  = ($urandom_range(0, 2) == 0);
        left_lc = $urandom_range(1, 9);
      end
      left_ss--;
      left_lc--;
      step();
      checks++;
      if ({cnt_en, cnt_rst, disp_freeze, state_o} !== m_outs()) begin
        errors++;
        $display("FAIL random_cycle n=%0d: got %b expected %b", n,
                 {cnt_en, cnt_rst, disp_freeze, state_o}, m_outs());
      end
    end
    btn_ss = 1'b0;
    btn_lc = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_start_hold();
    test_glitch_lap();
    test_pause_resume();
    test_clear();
    test_simultaneous();
    test_reset_midrun();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule
